// File: rtl/rv_bus_pkg.sv
// Shared bus types for the RV32I memory ports.
// State encoding, field widths and fault codes.
package rv_bus_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] FLT_NONE  = 2'd0;
  localparam logic [1:0] FLT_RANGE = 2'd1;
  localparam logic [1:0] FLT_ALIGN = 2'd2;

  // Range is checked in XLEN+1 bits so a window
  // ending at the top of memory cannot wrap.
  function automatic logic [1:0] addr_fault(
    input logic [XLEN-1:0] addr,
    input logic [XLEN-1:0] base,
    input logic [XLEN-1:0] nbytes
  );
    logic [XLEN:0] a;
    logic [XLEN:0] lo;
    logic [XLEN:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = {1'b0, base} + {1'b0, nbytes};
    if (addr[1:0] != 2'b00)
      return FLT_ALIGN;
    else if (a < lo || a >= hi)
      return FLT_RANGE;
    else
      return FLT_NONE;
  endfunction

endpackage

// File: rtl/rv_dmem_responder_if.sv
// Data-memory request/response bus.
// master = core LSU side, slave = responder.
interface rv_dmem_responder_if;
  import rv_bus_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [BE_W-1:0] req_be;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_be, req_wdata, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_be, req_wdata, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );

endinterface

// File: rtl/rv_sp_ram.sv
// Single-port word RAM, synchronous read,
// per-byte write enables. Contents not reset.
module rv_sp_ram
  import rv_bus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic            i_clk,
  input  logic            i_en,
  input  logic            i_we,
  input  logic [BE_W-1:0] i_be,
  input  logic [AW-1:0]   i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_rdata
);

  logic [XLEN-1:0] r_mem [DEPTH_WORDS];
  logic [XLEN-1:0] r_rdata;

  // One access per enabled cycle: lane write or word read.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (i_be[b])
            r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/rv_dmem_responder.sv
// Data-memory responder: one request in flight,
// fixed wait states, registered response.
module rv_dmem_responder
  import rv_bus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  rv_dmem_responder_if.slave io_bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] NBYTES = XLEN'(DEPTH_WORDS * 4);
  localparam logic [3:0] WS_LOAD =
    (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e          r_state;
  state_e          w_next;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_next;
  logic            w_enter_resp;

  logic            r_we;
  logic            r_err;
  logic [AW-1:0]   r_idx;
  logic [BE_W-1:0] r_be;
  logic [XLEN-1:0] r_wdata;

  logic            w_accept;
  logic            w_req_err;
  logic [AW-1:0]   w_req_idx;
  logic            w_sel_req;
  logic            w_op_we;
  logic            w_op_err;
  logic [AW-1:0]   w_op_idx;
  logic [BE_W-1:0] w_op_be;
  logic [XLEN-1:0] w_op_wdata;
  logic [XLEN-1:0] w_ram_rdata;

  assign w_accept  = io_bus.req_valid && (r_state == ST_IDLE);
  assign w_req_err =
    |addr_fault(io_bus.req_addr, BASE_ADDR, NBYTES);
  assign w_req_idx =
    AW'((io_bus.req_addr - BASE_ADDR) >> 2);

  // Zero-wait builds enter RESP straight from IDLE,
  // so the RAM must see the live request then.
  assign w_sel_req  = (r_state == ST_IDLE);
  assign w_op_we    = w_sel_req ? io_bus.req_we    : r_we;
  assign w_op_err   = w_sel_req ? w_req_err        : r_err;
  assign w_op_idx   = w_sel_req ? w_req_idx        : r_idx;
  assign w_op_be    = w_sel_req ? io_bus.req_be    : r_be;
  assign w_op_wdata = w_sel_req ? io_bus.req_wdata : r_wdata;

  // State and wait counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic: IDLE -> WAIT -> RESP -> IDLE.
  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    w_enter_resp = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (WAIT_STATES == 0) begin
            w_next       = ST_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next     = ST_WAIT;
            w_cnt_next = WS_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next       = ST_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        if (io_bus.rsp_ready)
          w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Capture the request and its fault verdict on accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_be    <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= io_bus.req_we;
      r_err   <= w_req_err;
      r_idx   <= w_req_idx;
      r_be    <= io_bus.req_be;
      r_wdata <= io_bus.req_wdata;
    end
  end

  rv_sp_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_en    (w_enter_resp && !w_op_err),
    .i_we    (w_op_we),
    .i_be    (w_op_be),
    .i_addr  (w_op_idx),
    .i_wdata (w_op_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign io_bus.req_ready = (r_state == ST_IDLE);
  assign io_bus.rsp_valid = (r_state == ST_RESP);
  assign io_bus.rsp_err   = (r_state == ST_RESP) && r_err;
  assign io_bus.rsp_rdata =
    (r_state == ST_RESP && !r_we && !r_err) ?
    w_ram_rdata : '0;

endmodule

// File: tb/tb_rv_dmem_responder.sv
// Directed bench for rv_dmem_responder (WAIT_STATES 2 and 0)
// plus a random pass on the zero-wait build against a word model.
module tb_rv_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv_dmem_responder_if b0 ();
  rv_dmem_responder_if b1 ();

  rv_dmem_responder #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0000_1000),
    .WAIT_STATES (2)
  ) dut0 (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (b0)
  );

  rv_dmem_responder #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0000_1000),
    .WAIT_STATES (0)
  ) dut1 (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (b1)
  );

  virtual rv_dmem_responder_if vif;

  int n_pass = 0;
  int n_total = 0;

  task automatic init_bus();
    vif.req_valid = 1'b0;
    vif.req_we    = 1'b0;
    vif.req_addr  = '0;
    vif.req_be    = '0;
    vif.req_wdata = '0;
    vif.rsp_ready = 1'b1;
  endtask

  // Drives one request; lat counts cycles from the accept cycle
  // to the first cycle with rsp_valid. ok=0 on timeout.
  task automatic do_req(
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        err,
    output int          lat,
    output bit          ok
  );
    int guard;
    ok = 0; rdata = '0; err = 1'b0; lat = 0;
    vif.req_valid = 1'b1;
    vif.req_we    = we;
    vif.req_addr  = addr;
    vif.req_be    = be;
    vif.req_wdata = wdata;
    vif.rsp_ready = 1'b1;
    guard = 0;
    while (!vif.req_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (!vif.req_ready) begin
      vif.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    vif.req_valid = 1'b0;
    lat = 1;
    while (!vif.rsp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!vif.rsp_valid) return;
    rdata = vif.rsp_rdata;
    err   = vif.rsp_err;
    ok    = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if (b0.req_ready !== 1'b1 || b0.rsp_valid !== 1'b0)
      $display("FAIL reset_hs got rdy=%b vld=%b want rdy=1 vld=0",
               b0.req_ready, b0.rsp_valid);
    else n_pass++;
    n_total++;
    if (b0.rsp_rdata !== 32'h0 || b0.rsp_err !== 1'b0)
      $display("FAIL reset_data got %h/%b want 0/0",
               b0.rsp_rdata, b0.rsp_err);
    else n_pass++;
    n_total++;
    if (b1.req_ready !== 1'b1 || b1.rsp_valid !== 1'b0)
      $display("FAIL reset_ws0 got rdy=%b vld=%b want rdy=1 vld=0",
               b1.req_ready, b1.rsp_valid);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat; bit ok;
    vif = b0;
    do_req(1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, rd, er, lat, ok);
    n_total++;
    if (!ok || lat !== 3 || er !== 1'b0 || rd !== 32'h0)
      $display("FAIL st_1000 got ok=%0d lat=%0d err=%b rd=%h want 1/3/0/0",
               ok, lat, er, rd);
    else n_pass++;
    do_req(1'b0, 32'h1000, 4'h0, 32'h0, rd, er, lat, ok);
    n_total++;
    if (!ok || lat !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF)
      $display("FAIL ld_1000 got ok=%0d lat=%0d err=%b rd=%h want 1/3/0/deadbeef",
               ok, lat, er, rd);
    else n_pass++;
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic er; int lat; bit ok;
    vif = b0;
    do_req(1'b1, 32'h1004, 4'hF, 32'hFFFFFFFF, rd, er, lat, ok);
    do_req(1'b1, 32'h1004, 4'h1, 32'h000000AA, rd, er, lat, ok);
    do_req(1'b1, 32'h1004, 4'h2, 32'h0000BB00, rd, er, lat, ok);
    do_req(1'b0, 32'h1004, 4'h0, 32'h0, rd, er, lat, ok);
    n_total++;
    if (!ok || er !== 1'b0 || rd !== 32'hFFFFBBAA)
      $display("FAIL lanes got ok=%0d err=%b rd=%h want 1/0/ffffbbaa",
               ok, er, rd);
    else n_pass++;
    do_req(1'b1, 32'h1004, 4'h0, 32'h12345678, rd, er, lat, ok);
    n_total++;
    if (!ok || er !== 1'b0)
      $display("FAIL be0_st got ok=%0d err=%b want 1/0", ok, er);
    else n_pass++;
    do_req(1'b0, 32'h1004, 4'h0, 32'h0, rd, er, lat, ok);
    n_total++;
    if (!ok || rd !== 32'hFFFFBBAA)
      $display("FAIL be0_ld got ok=%0d rd=%h want 1/ffffbbaa", ok, rd);
    else n_pass++;
  endtask

  task automatic test_faults();
    logic [31:0] rd; logic er; int lat; bit ok;
    logic [31:0] bad [3];
    vif = b0;
    bad[0] = 32'h0FFC; bad[1] = 32'h2000; bad[2] = 32'h1002;
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, bad[i], 4'h0, 32'h0, rd, er, lat, ok);
      n_total++;
      if (!ok || er !== 1'b1 || rd !== 32'h0 || lat !== 3)
        $display("FAIL fault_ld_%h got ok=%0d err=%b rd=%h lat=%0d want 1/1/0/3",
                 bad[i], ok, er, rd, lat);
      else n_pass++;
    end
    do_req(1'b1, 32'h2000, 4'hF, 32'h11111111, rd, er, lat, ok);
    n_total++;
    if (!ok || er !== 1'b1 || rd !== 32'h0)
      $display("FAIL fault_st got ok=%0d err=%b rd=%h want 1/1/0", ok, er, rd);
    else n_pass++;
    do_req(1'b0, 32'h1000, 4'h0, 32'h0, rd, er, lat, ok);
    n_total++;
    if (!ok || rd !== 32'hDEADBEEF)
      $display("FAIL word0_kept got ok=%0d rd=%h want 1/deadbeef", ok, rd);
    else n_pass++;
    do_req(1'b1, 32'h1FFC, 4'hF, 32'hCAFEF00D, rd, er, lat, ok);
    do_req(1'b0, 32'h1FFC, 4'h0, 32'h0, rd, er, lat, ok);
    n_total++;
    if (!ok || er !== 1'b0 || rd !== 32'hCAFEF00D)
      $display("FAIL last_word got ok=%0d err=%b rd=%h want 1/0/cafef00d",
               ok, er, rd);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int guard;
    vif = b0;
    vif.rsp_ready = 1'b0;
    vif.req_valid = 1'b1;
    vif.req_we    = 1'b0;
    vif.req_addr  = 32'h1000;
    vif.req_be    = 4'h0;
    @(posedge clk); #1;
    guard = 0;
    while (!vif.rsp_valid && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (vif.rsp_valid !== 1'b1 || vif.rsp_rdata !== 32'hDEADBEEF ||
          vif.req_ready !== 1'b0)
        $display("FAIL hold_%0d got vld=%b rd=%h rdy=%b want 1/deadbeef/0",
                 i, vif.rsp_valid, vif.rsp_rdata, vif.req_ready);
      else n_pass++;
      @(posedge clk); #1;
    end
    vif.rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (vif.req_ready !== 1'b1 || vif.rsp_valid !== 1'b0)
      $display("FAIL after_hs got rdy=%b vld=%b want 1/0",
               vif.req_ready, vif.rsp_valid);
    else n_pass++;
    vif.req_addr = 32'h1004;
    @(posedge clk); #1;
    n_total++;
    if (vif.req_ready !== 1'b0)
      $display("FAIL second_acc got rdy=%b want 0", vif.req_ready);
    else n_pass++;
    vif.req_valid = 1'b0;
    guard = 0;
    while (!vif.rsp_valid && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    n_total++;
    if (vif.rsp_valid !== 1'b1 || vif.rsp_rdata !== 32'hFFFFBBAA)
      $display("FAIL second_rsp got vld=%b rd=%h want 1/ffffbbaa",
               vif.rsp_valid, vif.rsp_rdata);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; bit ok; bit seen;
    vif = b0;
    do_req(1'b1, 32'h1008, 4'hF, 32'h0, rd, er, lat, ok);
    vif.req_valid = 1'b1;
    vif.req_we    = 1'b1;
    vif.req_addr  = 32'h1008;
    vif.req_be    = 4'hF;
    vif.req_wdata = 32'h12345678;
    @(posedge clk); #1;
    vif.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_total++;
    if (vif.req_ready !== 1'b1 || vif.rsp_valid !== 1'b0 ||
        vif.rsp_err !== 1'b0 || vif.rsp_rdata !== 32'h0)
      $display("FAIL rst_mid got rdy=%b vld=%b err=%b rd=%h want 1/0/0/0",
               vif.req_ready, vif.rsp_valid, vif.rsp_err, vif.rsp_rdata);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (vif.rsp_valid) seen = 1;
    end
    n_total++;
    if (seen !== 1'b0)
      $display("FAIL rst_no_rsp got seen=%b want 0", seen);
    else n_pass++;
    do_req(1'b0, 32'h1008, 4'h0, 32'h0, rd, er, lat, ok);
    n_total++;
    if (!ok || rd !== 32'h0 || er !== 1'b0)
      $display("FAIL rst_dropped got ok=%0d rd=%h err=%b want 1/0/0",
               ok, rd, er);
    else n_pass++;
  endtask

  task automatic test_ws0_random();
    logic [31:0] model [16];
    logic [31:0] rd; logic er; int lat; bit ok;
    logic [31:0] addr, wd, exp_rd;
    logic [3:0] be;
    logic we, exp_err;
    int idx, kind;
    vif = b1;
    init_bus();
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      do_req(1'b1, 32'h1000 + 32'(i*4), 4'hF, model[i], rd, er, lat, ok);
    end
    n_total++;
    if (!ok || lat !== 1)
      $display("FAIL ws0_lat got ok=%0d lat=%0d want 1/1", ok, lat);
    else n_pass++;
    for (int n = 0; n < 100; n++) begin
      idx  = int'($urandom_range(0, 15));
      kind = int'($urandom_range(0, 7));
      we   = 1'($urandom);
      be   = 4'($urandom);
      wd   = $urandom;
      addr = 32'h1000 + 32'(idx*4);
      exp_err = 1'b0;
      if (kind == 0) begin
        addr = addr + 32'd2; exp_err = 1'b1;
      end else if (kind == 1) begin
        addr = 32'h0FF0; exp_err = 1'b1;
      end
      exp_rd = 32'h0;
      if (!exp_err) begin
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
        end else begin
          exp_rd = model[idx];
        end
      end
      do_req(we, addr, be, wd, rd, er, lat, ok);
      n_total++;
      if (!ok || lat !== 1 || er !== exp_err || rd !== exp_rd)
        $display("FAIL ws0_op%0d got ok=%0d lat=%0d err=%b rd=%h want 1/1/%b/%h",
                 n, ok, lat, er, rd, exp_err, exp_rd);
      else n_pass++;
    end
  endtask

  initial begin
    vif = b1;
    init_bus();
    vif = b0;
    init_bus();
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_faults();
    test_backpressure();
    test_reset_mid();
    test_ws0_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
